// File: rtl/execute_pipe.sv
// Execute stage with valid/ready handshake, flush and a multi-cycle multiplier.
// Single-cycle ALU/branch ops complete in one edge; MUL/MULH/MULHU take MUL_LAT cycles.
module execute_pipe #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4,
  parameter int EN_MUL  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] r1_data,
  input  logic [XLEN-1:0] r2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      alucode,
  input  logic [1:0]      mulop,
  input  logic            using_r2,
  input  logic            using_pc,
  input  logic            write_reg,
  input  logic [2:0]      info_load,
  input  logic [1:0]      info_store,
  input  logic [3:0]      info_branch,
  input  logic [4:0]      dstreg_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic [XLEN-1:0] rs2E,
  output logic            write_regE,
  output logic [2:0]      info_loadE,
  output logic [1:0]      info_storeE,
  output logic [4:0]      dstreg_addrE,
  output logic            busy
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_op_e;

  typedef enum logic [1:0] {
    MUL_NONE  = 2'b00,
    MUL_LO    = 2'b01,
    MUL_HI_SS = 2'b10,
    MUL_HI_UU = 2'b11
  } mul_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] next_pc;
    logic            redirect;
    logic [XLEN-1:0] rs2;
    logic            write_reg;
    logic [2:0]      info_load;
    logic [1:0]      info_store;
    logic [4:0]      dstreg_addr;
  } result_t;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [1:0]      mulop;
    logic            write_reg;
    logic [2:0]      info_load;
    logic [1:0]      info_store;
    logic [4:0]      dstreg_addr;
  } mul_op_t;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] code,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (code)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << sh;
      ALU_SLT:   return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  return {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return $signed(a) >>> sh;
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      ALU_PASSB: return b;
      default:   return '0;
    endcase
  endfunction

  state_e          state;
  logic [CW-1:0]   cnt;
  result_t         out_q;
  mul_op_t         mul_q;

  logic            can_load;
  logic            accept;
  logic            mul_req;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic            taken;
  logic            is_jump;
  result_t         single_res;
  result_t         mul_res;
  logic [2*XLEN-1:0] prod_uu;
  logic [2*XLEN-1:0] prod_ss;

  assign can_load = ~out_valid | out_ready;
  assign in_ready = (state == S_IDLE) & can_load;
  assign accept   = in_valid & in_ready & ~flush;
  assign mul_req  = (EN_MUL != 0) && (mulop != MUL_NONE);

  assign op_a     = using_pc ? pc : r1_data;
  assign op_b     = using_r2 ? r2_data : imm;
  assign pc_plus4 = pc + XLEN'(4);
  assign is_jump  = (info_branch == BR_JAL) || (info_branch == BR_JALR);

  // JALR target clears bit 0; all other transfers are pc-relative.
  assign br_target = (info_branch == BR_JALR) ? ((r1_data + imm) & ~XLEN'(1)) : (pc + imm);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    taken = 1'b0;
    case (info_branch)
      BR_BEQ:  taken = (r1_data == r2_data);
      BR_BNE:  taken = (r1_data != r2_data);
      BR_BLT:  taken = ($signed(r1_data) <  $signed(r2_data));
      BR_BGE:  taken = ($signed(r1_data) >= $signed(r2_data));
      BR_BLTU: taken = (r1_data <  r2_data);
      BR_BGEU: taken = (r1_data >= r2_data);
      BR_JAL,
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    single_res             = '0;
    single_res.alu_result  = is_jump ? pc_plus4 : alu_f(alucode, op_a, op_b);
    single_res.next_pc     = taken ? br_target : pc_plus4;
    single_res.redirect    = taken;
    single_res.rs2         = r2_data;
    single_res.write_reg   = write_reg;
    single_res.info_load   = info_load;
    single_res.info_store  = info_store;
    single_res.dstreg_addr = dstreg_addr;
  end

  // Signed product: sign-extend to 2*XLEN, the low 2*XLEN bits are then exact.
  assign prod_uu = {{XLEN{1'b0}}, mul_q.a} * {{XLEN{1'b0}}, mul_q.b};
  assign prod_ss = {{XLEN{mul_q.a[XLEN-1]}}, mul_q.a} * {{XLEN{mul_q.b[XLEN-1]}}, mul_q.b};

  always_comb begin
    mul_res             = '0;
    case (mul_q.mulop)
      MUL_LO:    mul_res.alu_result = prod_uu[XLEN-1:0];
      MUL_HI_SS: mul_res.alu_result = prod_ss[2*XLEN-1:XLEN];
      MUL_HI_UU: mul_res.alu_result = prod_uu[2*XLEN-1:XLEN];
      default:   mul_res.alu_result = '0;
    endcase
    mul_res.next_pc     = mul_q.pc + XLEN'(4);
    mul_res.redirect    = 1'b0;
    mul_res.rs2         = mul_q.b;
    mul_res.write_reg   = mul_q.write_reg;
    mul_res.info_load   = mul_q.info_load;
    mul_res.info_store  = mul_q.info_store;
    mul_res.dstreg_addr = mul_q.dstreg_addr;
  end

  // NOTE: the multiply operand latch has no reset; it is only read after an accept wrote it.
  always_ff @(posedge clk) begin
    if (accept && mul_req) begin
      mul_q.a           <= r1_data;
      mul_q.b           <= r2_data;
      mul_q.pc          <= pc;
      mul_q.mulop       <= mulop;
      mul_q.write_reg   <= write_reg;
      mul_q.info_load   <= info_load;
      mul_q.info_store  <= info_store;
      mul_q.dstreg_addr <= dstreg_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so later writes in the block win cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      state          <= S_IDLE;
      cnt            <= '0;
      busy           <= 1'b0;
      out_valid      <= 1'b0;
      out_q.redirect <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (mul_req) begin
              state     <= S_MUL;
              busy      <= 1'b1;
              cnt       <= CW'(MUL_LAT - 1);
              out_valid <= 1'b0;
            end else begin
              out_q     <= single_res;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (out_ready) out_valid <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (can_load) begin
            out_q     <= mul_res;
            out_valid <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign alu_result   = out_q.alu_result;
  assign next_pc      = out_q.next_pc;
  assign redirect     = out_q.redirect;
  assign rs2E         = out_q.rs2;
  assign write_regE   = out_q.write_reg;
  assign info_loadE   = out_q.info_load;
  assign info_storeE  = out_q.info_store;
  assign dstreg_addrE = out_q.dstreg_addr;

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_execute_pipe;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 4;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9, A_PASSB = 4'd10;
  localparam logic [3:0] B_NONE = 4'd0, B_BEQ = 4'd1, B_BNE = 4'd2, B_BLT = 4'd3,
                         B_BGE = 4'd4, B_BLTU = 4'd5, B_BGEU = 4'd6, B_JAL = 4'd7,
                         B_JALR = 4'd8;

  typedef struct {
    logic [31:0] r1, r2, imm, pc;
    logic [3:0]  alu;
    logic [1:0]  mul;
    logic        ur2, upc;
    logic [3:0]  br;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [4:0]  rd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic [31:0] r1_data, r2_data, imm, pc;
  logic [3:0]  alucode;
  logic [1:0]  mulop;
  logic        using_r2, using_pc, write_reg;
  logic [2:0]  info_load;
  logic [1:0]  info_store;
  logic [3:0]  info_branch;
  logic [4:0]  dstreg_addr;
  logic        out_valid, out_ready;
  logic [31:0] alu_result, next_pc, rs2E;
  logic        redirect, write_regE, busy;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;

  int errors = 0;
  int checks = 0;

  execute_pipe #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .EN_MUL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .r1_data(r1_data), .r2_data(r2_data), .imm(imm), .pc(pc), .alucode(alucode),
    .mulop(mulop), .using_r2(using_r2), .using_pc(using_pc), .write_reg(write_reg),
    .info_load(info_load), .info_store(info_store), .info_branch(info_branch),
    .dstreg_addr(dstreg_addr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .next_pc(next_pc), .redirect(redirect), .rs2E(rs2E),
    .write_regE(write_regE), .info_loadE(info_loadE), .info_storeE(info_storeE),
    .dstreg_addrE(dstreg_addrE), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: straight from the architectural definition of each op.
  function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (code)
      A_ADD:   return a + b;
      A_SUB:   return a - b;
      A_SLL:   return a << sh;
      A_SLT:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      A_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      A_XOR:   return a ^ b;
      A_SRL:   return a >> sh;
      A_SRA:   return 32'(int'(a) >>> sh);
      A_OR:    return a | b;
      A_AND:   return a & b;
      A_PASSB: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_model(input op_t o, output logic [31:0] res, output logic [31:0] npc,
                           output logic red);
    longint          ps;
    longint unsigned pu;
    logic            t;
    logic [31:0]     tgt;
    if (o.mul != 2'b00) begin
      ps  = longint'(int'(o.r1)) * longint'(int'(o.r2));
      pu  = longint'({32'd0, o.r1}) * longint'({32'd0, o.r2});
      res = (o.mul == 2'b01) ? pu[31:0] : (o.mul == 2'b10) ? ps[63:32] : pu[63:32];
      npc = o.pc + 32'd4;
      red = 1'b0;
    end else begin
      case (o.br)
        B_BEQ:  t = (o.r1 == o.r2);
        B_BNE:  t = (o.r1 != o.r2);
        B_BLT:  t = (int'(o.r1) < int'(o.r2));
        B_BGE:  t = (int'(o.r1) >= int'(o.r2));
        B_BLTU: t = (o.r1 < o.r2);
        B_BGEU: t = (o.r1 >= o.r2);
        B_JAL, B_JALR: t = 1'b1;
        default: t = 1'b0;
      endcase
      tgt = (o.br == B_JALR) ? ((o.r1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
      if (o.br == B_JAL || o.br == B_JALR) res = o.pc + 32'd4;
      else res = ref_alu(o.alu, o.upc ? o.pc : o.r1, o.ur2 ? o.r2 : o.imm);
      npc = t ? tgt : o.pc + 32'd4;
      red = t;
    end
  endtask

  task automatic drive(input op_t o, input logic v);
    in_valid = v; r1_data = o.r1; r2_data = o.r2; imm = o.imm; pc = o.pc;
    alucode = o.alu; mulop = o.mul; using_r2 = o.ur2; using_pc = o.upc;
    info_branch = o.br; write_reg = o.wr; info_load = o.ld; info_store = o.st;
    dstreg_addr = o.rd;
  endtask

  function automatic op_t mk(input logic [3:0] alu, input logic [1:0] mul, input logic [3:0] br,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] im, input logic [31:0] p);
    op_t o;
    o.r1 = r1; o.r2 = r2; o.imm = im; o.pc = p; o.alu = alu; o.mul = mul; o.br = br;
    o.ur2 = 1'b1; o.upc = 1'b0; o.wr = 1'b1; o.ld = 3'd2; o.st = 2'd1; o.rd = 5'd9;
    return o;
  endfunction

  // Issue one op, wait for its result, optionally hold it with out_ready low, then drain.
  task automatic run_op(input op_t o, input string tag, input int hold);
    int          n;
    logic [31:0] e_res, e_npc;
    logic        e_red;
    ref_model(o, e_res, e_npc, e_red);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    drive(o, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      if (o.mul != 2'b00) check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), (o.mul != 2'b00) ? 64'(MUL_LAT) : 64'd0);
    check({tag, "_alu_result"}, 64'(alu_result), 64'(e_res));
    check({tag, "_next_pc"}, 64'(next_pc), 64'(e_npc));
    check({tag, "_redirect"}, 64'(redirect), 64'(e_red));
    check({tag, "_sideband"}, {rs2E, write_regE, info_loadE, info_storeE, dstreg_addrE},
          {o.r2, o.wr, o.ld, o.st, o.rd});
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_data"}, 64'(alu_result), 64'(e_res));
        check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    op_t o;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(mk(A_ADD, 2'b00, B_NONE, 0, 0, 0, 0), 1'b0);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_data", {alu_result, next_pc}, 64'd0);
    check("reset_redirect", 64'(redirect), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    run_op(mk(A_ADD, 2'b00, B_NONE, 5, 7, 0, 32'h40), "add", 0);
    run_op(mk(A_SUB, 2'b00, B_BEQ, 3, 3, 32'h20, 32'h100), "beq", 0);
    run_op(mk(A_ADD, 2'b00, B_JAL, 0, 0, 8, 32'hFFFF_FFFC), "jal_wrap", 0);
    run_op(mk(A_ADD, 2'b10, B_NONE, 32'hFFFF_FFFF, 2, 0, 32'h200), "mulh", 0);
    run_op(mk(A_ADD, 2'b11, B_NONE, 32'hFFFF_FFFF, 2, 0, 32'h204), "mulhu", 0);
    run_op(mk(A_XOR, 2'b00, B_NONE, 32'hA5A5_0000, 32'h0F0F_0F0F, 0, 0), "backpressure", 3);
    run_op(mk(A_ADD, 2'b00, B_NONE, 1, 2, 0, 0), "after_backpressure", 0);

    // Reset while the multiplier is counting (cnt=2).
    drive(mk(A_ADD, 2'b01, B_NONE, 6, 7, 0, 0), 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("mid_mul_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Flush at cnt=1: the multiply result must never surface.
    drive(mk(A_ADD, 2'b01, B_NONE, 6, 7, 0, 0), 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    run_op(mk(A_ADD, 2'b00, B_NONE, 100, 23, 0, 0), "add_after_flush", 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_mul", 64'(out_valid), 64'd0);
    end

    // An op presented together with flush is dropped.
    drive(mk(A_ADD, 2'b00, B_NONE, 1, 1, 0, 0), 1'b1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    check("flush_blocks_accept", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("flush_blocks_accept_late", 64'(out_valid), 64'd0);

    for (int k = 0; k < 40; k++) begin
      o.r1  = $urandom;
      o.r2  = ($urandom_range(0, 3) == 0) ? o.r1 : $urandom;
      o.imm = $urandom;
      o.pc  = $urandom & 32'hFFFF_FFFC;
      o.alu = 4'($urandom_range(0, 10));
      o.mul = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      o.br  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 8)) : B_NONE;
      o.ur2 = 1'($urandom); o.upc = 1'($urandom);
      o.wr  = 1'($urandom); o.ld = 3'($urandom); o.st = 2'($urandom); o.rd = 5'($urandom);
      run_op(o, $sformatf("rand%0d", k), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
